vga_output_stage: RTL and testbench

- Parametrised VGA output stage between the user's RGB565-style colour outputs and the board's low-bit-depth VGA DAC pins.
- Reduces each colour channel to W_OUT bits, blanks colour outside the active area and pipelines colour and sync so they stay aligned.
- Runs a sync monitor that drives a sticky self-diagnostic failure flag.
- Instantiated in the top glue layer after the VGA timing generator.

---
 rtl/vga_output_stage.sv | 241 ++++++++++++++++++++++++
 tb/tb_vga_output_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_output_stage.sv
// vga_output_stage: two-stage VGA output pipeline.
// Reduces each RGB channel to W_OUT bits, blanks colour outside the active
// area, keeps sync aligned with colour, and monitors the number of hsync
// pulses per frame with a sticky failure flag.
// Optional build macro: VGA_OUTPUT_STAGE_DITHER_EN selects 4x4 ordered (Bayer)
// dithering instead of the OR-reduction rule for channels that lose bits.

// Per-channel width reduction; purely combinational.
module vga_channel_reduce #(
    parameter int W_IN  = 5,
    parameter int W_OUT = 2
) (
    input  logic [W_IN-1:0]  i_value,
`ifdef VGA_OUTPUT_STAGE_DITHER_EN
    input  logic [1:0]       i_hposLow,
    input  logic [1:0]       i_vposLow,
`endif
    output logic [W_OUT-1:0] o_value
);
    localparam int D = W_IN - W_OUT;

    generate
        if (D == 0) begin : g_pass
            assign o_value = i_value;
        end
`ifdef VGA_OUTPUT_STAGE_DITHER_EN
        else begin : g_dither
            logic [3:0]    w_threshold;
            logic [W_IN:0] w_scaled;
            logic [W_IN:0] w_sum;

            // Bayer threshold lookup indexed by {row, column} of the pixel
            always_comb begin
                w_threshold = 4'd0;
                case ({i_vposLow, i_hposLow})
                    4'h0: w_threshold = 4'd0;
                    4'h1: w_threshold = 4'd8;
                    4'h2: w_threshold = 4'd2;
                    4'h3: w_threshold = 4'd10;
                    4'h4: w_threshold = 4'd12;
                    4'h5: w_threshold = 4'd4;
                    4'h6: w_threshold = 4'd14;
                    4'h7: w_threshold = 4'd6;
                    4'h8: w_threshold = 4'd3;
                    4'h9: w_threshold = 4'd11;
                    4'hA: w_threshold = 4'd1;
                    4'hB: w_threshold = 4'd9;
                    4'hC: w_threshold = 4'd15;
                    4'hD: w_threshold = 4'd7;
                    4'hE: w_threshold = 4'd13;
                    default: w_threshold = 4'd5;
                endcase
            end

            // Scale the 4-bit threshold to span exactly the dropped bits
            if (D >= 4) begin : g_up
                assign w_scaled = (W_IN+1)'(w_threshold) << (D - 4);
            end else begin : g_down
                assign w_scaled = (W_IN+1)'(w_threshold >> (4 - D));
            end

            assign w_sum   = {1'b0, i_value} + w_scaled;
            assign o_value = w_sum[W_IN] ? {W_OUT{1'b1}} : w_sum[W_IN-1:D];
        end
`else
        else if (W_OUT == 1) begin : g_single
            assign o_value = |i_value;
        end else begin : g_or
            assign o_value = {i_value[W_IN-1 -: W_OUT-1], |i_value[D:0]};
        end
`endif
    endgenerate
endmodule

module vga_output_stage #(
    parameter int W_R_IN          = 5,
    parameter int W_G_IN          = 6,
    parameter int W_B_IN          = 5,
    parameter int W_OUT           = 2,
    parameter int W_POS           = 10,
    parameter int LINES_PER_FRAME = 525,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_hsync,
    input  logic              in_vsync,
    input  logic              in_display_on,
    input  logic [W_POS-1:0]  hpos,
    input  logic [W_POS-1:0]  vpos,
    input  logic [W_R_IN-1:0] red,
    input  logic [W_G_IN-1:0] green,
    input  logic [W_B_IN-1:0] blue,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic [W_OUT-1:0]  vga_red,
    output logic [W_OUT-1:0]  vga_green,
    output logic [W_OUT-1:0]  vga_blue,
    output logic              frame_start,
    output logic              sticky_failure
);
    localparam logic SYNC_IDLE   = SYNC_ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic SYNC_ACTIVE = ~SYNC_IDLE;
    // One spare bit above the expected count so saturation never aliases it
    localparam int   CNT_W       = $clog2(LINES_PER_FRAME + 1) + 1;

    typedef enum logic {
        WAIT_FRAME,
        COUNT
    } monitorState_t;

    logic              r_hsync1;
    logic              r_vsync1;
    logic              r_displayOn1;
    logic [W_R_IN-1:0] r_red1;
    logic [W_G_IN-1:0] r_green1;
    logic [W_B_IN-1:0] r_blue1;

    logic [W_OUT-1:0]  w_redReduced;
    logic [W_OUT-1:0]  w_greenReduced;
    logic [W_OUT-1:0]  w_blueReduced;

    logic              w_hsyncEdge;
    logic              w_vsyncEdge;
    logic [CNT_W-1:0]  w_countNext;
    logic [CNT_W-1:0]  w_closingCount;

    monitorState_t     r_state;
    logic [CNT_W-1:0]  r_lineCount;

`ifdef VGA_OUTPUT_STAGE_DITHER_EN
    logic [1:0]        r_hposLow1;
    logic [1:0]        r_vposLow1;
    logic              w_unusedPos;

    assign w_unusedPos = ^{hpos[W_POS-1:2], vpos[W_POS-1:2]};

    // Stage 1 position capture; only the low bits feed the dither matrix
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hposLow1 <= 2'd0;
            r_vposLow1 <= 2'd0;
        end else begin
            r_hposLow1 <= hpos[1:0];
            r_vposLow1 <= vpos[1:0];
        end
    end

    vga_channel_reduce #(.W_IN(W_R_IN), .W_OUT(W_OUT)) u_reduceRed (
        .i_value(r_red1), .i_hposLow(r_hposLow1), .i_vposLow(r_vposLow1), .o_value(w_redReduced));
    vga_channel_reduce #(.W_IN(W_G_IN), .W_OUT(W_OUT)) u_reduceGreen (
        .i_value(r_green1), .i_hposLow(r_hposLow1), .i_vposLow(r_vposLow1), .o_value(w_greenReduced));
    vga_channel_reduce #(.W_IN(W_B_IN), .W_OUT(W_OUT)) u_reduceBlue (
        .i_value(r_blue1), .i_hposLow(r_hposLow1), .i_vposLow(r_vposLow1), .o_value(w_blueReduced));
`else
    logic w_unusedPos;

    assign w_unusedPos = ^{hpos, vpos};

    vga_channel_reduce #(.W_IN(W_R_IN), .W_OUT(W_OUT)) u_reduceRed (
        .i_value(r_red1), .o_value(w_redReduced));
    vga_channel_reduce #(.W_IN(W_G_IN), .W_OUT(W_OUT)) u_reduceGreen (
        .i_value(r_green1), .o_value(w_greenReduced));
    vga_channel_reduce #(.W_IN(W_B_IN), .W_OUT(W_OUT)) u_reduceBlue (
        .i_value(r_blue1), .o_value(w_blueReduced));
`endif

    // Stage 1: register every input so all paths share the same latency
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hsync1     <= SYNC_IDLE;
            r_vsync1     <= SYNC_IDLE;
            r_displayOn1 <= 1'b0;
            r_red1       <= '0;
            r_green1     <= '0;
            r_blue1      <= '0;
        end else begin
            r_hsync1     <= in_hsync;
            r_vsync1     <= in_vsync;
            r_displayOn1 <= in_display_on;
            r_red1       <= red;
            r_green1     <= green;
            r_blue1      <= blue;
        end
    end

    // Active edges: stage-1 value is active while the stage-2 copy is not yet
    assign w_hsyncEdge = (r_hsync1 == SYNC_ACTIVE) && (vga_hsync != SYNC_ACTIVE);
    assign w_vsyncEdge = (r_vsync1 == SYNC_ACTIVE) && (vga_vsync != SYNC_ACTIVE);

    // Stage 2: blanked reduced colour, delayed syncs and the frame marker
    always_ff @(posedge clock) begin
        if (reset) begin
            vga_hsync   <= SYNC_IDLE;
            vga_vsync   <= SYNC_IDLE;
            vga_red     <= '0;
            vga_green   <= '0;
            vga_blue    <= '0;
            frame_start <= 1'b0;
        end else begin
            vga_hsync   <= r_hsync1;
            vga_vsync   <= r_vsync1;
            vga_red     <= r_displayOn1 ? w_redReduced   : '0;
            vga_green   <= r_displayOn1 ? w_greenReduced : '0;
            vga_blue    <= r_displayOn1 ? w_blueReduced  : '0;
            frame_start <= w_vsyncEdge;
        end
    end

    // A coincident hsync edge belongs to the frame that the vsync edge closes
    assign w_countNext    = (r_lineCount == {CNT_W{1'b1}}) ? r_lineCount : r_lineCount + 1'b1;
    assign w_closingCount = w_hsyncEdge ? w_countNext : r_lineCount;

    // Line-count monitor; the first frame after reset is only used to align
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= WAIT_FRAME;
            r_lineCount    <= '0;
            sticky_failure <= 1'b0;
        end else begin
            case (r_state)
                WAIT_FRAME: begin
                    if (w_vsyncEdge) begin
                        r_lineCount <= '0;
                        r_state     <= COUNT;
                    end
                end
                default: begin
                    if (w_vsyncEdge) begin
                        if (w_closingCount != CNT_W'(LINES_PER_FRAME)) begin
                            sticky_failure <= 1'b1;
                        end
                        r_lineCount <= '0;
                    end else if (w_hsyncEdge) begin
                        r_lineCount <= w_countNext;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vga_output_stage.sv
// tb_vga_output_stage: directed self-checking bench for vga_output_stage with
// default parameters (active-low syncs, 525 lines per frame, 2-bit output).
// Colour checks follow whichever reduction rule the build selects through
// VGA_OUTPUT_STAGE_DITHER_EN.
module tb_vga_output_stage;
    logic       clock;
    logic       reset;
    logic       in_hsync;
    logic       in_vsync;
    logic       in_display_on;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic [4:0] red;
    logic [5:0] green;
    logic [4:0] blue;
    logic       vga_hsync;
    logic       vga_vsync;
    logic [1:0] vga_red;
    logic [1:0] vga_green;
    logic [1:0] vga_blue;
    logic       frame_start;
    logic       sticky_failure;

    int total = 0;
    int bad   = 0;

    vga_output_stage dut (
        .clock(clock),
        .reset(reset),
        .in_hsync(in_hsync),
        .in_vsync(in_vsync),
        .in_display_on(in_display_on),
        .hpos(hpos),
        .vpos(vpos),
        .red(red),
        .green(green),
        .blue(blue),
        .vga_hsync(vga_hsync),
        .vga_vsync(vga_vsync),
        .vga_red(vga_red),
        .vga_green(vga_green),
        .vga_blue(vga_blue),
        .frame_start(frame_start),
        .sticky_failure(sticky_failure)
    );

    // Free-running pixel clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic hs, input logic vs, input logic disp,
                                 input logic [4:0] r, input logic [5:0] g, input logic [4:0] b,
                                 input logic [9:0] hp, input logic [9:0] vp);
        in_hsync      = hs;
        in_vsync      = vs;
        in_display_on = disp;
        red           = r;
        green         = g;
        blue          = b;
        hpos          = hp;
        vpos          = vp;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_hsync"}, 16'(vga_hsync), 16'd1);
        checkOutput({tag, "_vsync"}, 16'(vga_vsync), 16'd1);
        checkOutput({tag, "_red"}, 16'(vga_red), 16'd0);
        checkOutput({tag, "_green"}, 16'(vga_green), 16'd0);
        checkOutput({tag, "_blue"}, 16'(vga_blue), 16'd0);
        checkOutput({tag, "_fs"}, 16'(frame_start), 16'd0);
        checkOutput({tag, "_sticky"}, 16'(sticky_failure), 16'd0);
    endtask

    task automatic checkColour(input string tag, input logic [1:0] r, input logic [1:0] g, input logic [1:0] b);
        checkOutput({tag, "_red"}, 16'(vga_red), 16'(r));
        checkOutput({tag, "_green"}, 16'(vga_green), 16'(g));
        checkOutput({tag, "_blue"}, 16'(vga_blue), 16'(b));
    endtask

    task automatic sendLines(input int n);
        repeat (n) begin
            in_hsync = 1'b0;
            tick();
            in_hsync = 1'b1;
            tick();
        end
    endtask

    // One-cycle vsync pulse, optionally with a coincident hsync pulse;
    // checks land on the cycle the delayed vsync goes active
    task automatic closeFrame(input string tag, input logic withHsync, input logic expectSticky);
        in_vsync = 1'b0;
        if (withHsync) in_hsync = 1'b0;
        tick();
        in_vsync = 1'b1;
        in_hsync = 1'b1;
        tick();
        checkOutput({tag, "_vsync"}, 16'(vga_vsync), 16'd0);
        checkOutput({tag, "_fs"}, 16'(frame_start), 16'd1);
        checkOutput({tag, "_sticky"}, 16'(sticky_failure), 16'(expectSticky));
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 5'b11111, 6'b111111, 5'b11111, 10'd3, 10'd3);

        // Reset held with busy inputs: outputs stay at reset values
        tick();
        checkIdle("rst0");
        applyStimulus(1'b1, 1'b0, 1'b1, 5'b10101, 6'b010101, 5'b01010, 10'd1, 10'd2);
        tick();
        checkIdle("rst1");
        applyStimulus(1'b0, 1'b1, 1'b0, 5'b11111, 6'b100000, 5'b00001, 10'd0, 10'd1);
        tick();
        checkIdle("rst2");

        reset = 1'b0;
`ifdef VGA_OUTPUT_STAGE_DITHER_EN
        // Dithered reduction at chosen matrix positions
        applyStimulus(1'b1, 1'b1, 1'b1, 5'b00010, 6'd0, 5'd0, 10'd1, 10'd0);
        tick(); tick();
        checkColour("dith_t8", 2'b00, 2'b00, 2'b00);
        applyStimulus(1'b1, 1'b1, 1'b1, 5'b00010, 6'd0, 5'd0, 10'd3, 10'd3);
        tick(); tick();
        checkColour("dith_t5", 2'b00, 2'b00, 2'b00);
        applyStimulus(1'b1, 1'b1, 1'b1, 5'b11111, 6'd0, 5'd0, 10'd0, 10'd3);
        tick(); tick();
        checkColour("dith_sat", 2'b11, 2'b00, 2'b00);
        applyStimulus(1'b1, 1'b1, 1'b1, 5'b00010, 6'd0, 5'd0, 10'd0, 10'd3);
        tick(); tick();
        checkColour("dith_t15", 2'b01, 2'b00, 2'b00);
`else
        // OR-rule reduction with two-clock latency
        applyStimulus(1'b1, 1'b1, 1'b1, 5'b10000, 6'b000001, 5'b00000, 10'd0, 10'd0);
        tick();
        checkColour("lat1", 2'b00, 2'b00, 2'b00);
        tick();
        checkColour("or_a", 2'b10, 2'b01, 2'b00);
        applyStimulus(1'b1, 1'b1, 1'b1, 5'b01000, 6'b100000, 5'b11111, 10'd0, 10'd0);
        tick(); tick();
        checkColour("or_b", 2'b01, 2'b10, 2'b11);
`endif
        // Blanking outside the active area
        applyStimulus(1'b1, 1'b1, 1'b0, 5'b10000, 6'b000001, 5'b11111, 10'd0, 10'd0);
        tick(); tick();
        checkColour("blank", 2'b00, 2'b00, 2'b00);

        // Single-cycle sync pulse appears exactly two clocks later
        in_hsync = 1'b0;
        in_vsync = 1'b0;
        tick();
        checkOutput("sync_n1_h", 16'(vga_hsync), 16'd1);
        checkOutput("sync_n1_v", 16'(vga_vsync), 16'd1);
        checkOutput("sync_n1_fs", 16'(frame_start), 16'd0);
        in_hsync = 1'b1;
        in_vsync = 1'b1;
        tick();
        checkOutput("sync_n2_h", 16'(vga_hsync), 16'd0);
        checkOutput("sync_n2_v", 16'(vga_vsync), 16'd0);
        checkOutput("sync_n2_fs", 16'(frame_start), 16'd1);
        tick();
        checkOutput("sync_n3_h", 16'(vga_hsync), 16'd1);
        checkOutput("sync_n3_v", 16'(vga_vsync), 16'd1);
        checkOutput("sync_n3_fs", 16'(frame_start), 16'd0);

        // Correct frames, the last with hsync coincident on the closing vsync
        sendLines(525);
        closeFrame("frame1", 1'b0, 1'b0);
        sendLines(525);
        closeFrame("frame2", 1'b0, 1'b0);
        sendLines(524);
        closeFrame("frame3_coinc", 1'b1, 1'b0);

        // Short frame latches the failure, which survives a good frame
        sendLines(524);
        closeFrame("frame_short", 1'b0, 1'b1);
        sendLines(525);
        closeFrame("frame_after", 1'b0, 1'b1);
        tick();
        checkOutput("sticky_hold", 16'(sticky_failure), 16'd1);

        reset = 1'b1;
        tick();
        checkIdle("rst_clear");
        reset = 1'b0;

        // Reset mid-frame, then a partial frame that must not be judged
        closeFrame("mid_start", 1'b0, 1'b0);
        sendLines(100);
        reset = 1'b1;
        tick(); tick();
        checkIdle("rst_mid");
        reset = 1'b0;
        sendLines(300);
        closeFrame("partial", 1'b0, 1'b0);
        sendLines(525);
        closeFrame("full_a", 1'b0, 1'b0);
        sendLines(525);
        closeFrame("full_b", 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
